// File: rtl/bpf_pkt_sched.sv
// bpf_pkt_sched: ping-pong packet buffer scheduler (snooper -> BPF CPU -> forwarder).
// Define BPF_CYC_LIMIT_EN to build the CPU cycle-budget watchdog.
module bpf_pkt_sched #(
  parameter int PLEN_WIDTH = 11,
  parameter int CYC_LIMIT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sn_start,
  output logic                  sn_grant,
  output logic                  sn_sel,
  input  logic                  sn_done,
  input  logic [PLEN_WIDTH-1:0] sn_len,
  output logic                  cpu_mem_ready,
  output logic                  cpu_sel,
  output logic [31:0]           packet_len,
  input  logic                  cpu_accept,
  input  logic                  cpu_reject,
  output logic                  cpu_abort,
  output logic                  fwd_valid,
  output logic                  fwd_sel,
  output logic [PLEN_WIDTH-1:0] fwd_len,
  input  logic                  fwd_done
);
  localparam logic [2:0] EMPTY = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] READY = 3'd2;
  localparam logic [2:0] FILT  = 3'd3;
  localparam logic [2:0] FWD   = 3'd4;

  logic [2:0]            st_q  [2];
  logic [2:0]            st_d  [2];
  logic [PLEN_WIDTH-1:0] len_q [2];
  logic [PLEN_WIDTH-1:0] len_d [2];
  logic                  ready_first, rf_d;
  logic                  fwd_first, ff_d;
  logic                  fill_any, filt_any;
  logic                  grant, gsel, start, ssel, abort;
  logic                  fill_s_d, filt_s_d, fwd_v_d, fwd_s_d;
  logic [31:0]           plen_d;
  logic [PLEN_WIDTH-1:0] flen_d;

`ifdef BPF_CYC_LIMIT_EN
  localparam int CW = $clog2(CYC_LIMIT + 1);
  logic [CW-1:0] cyc_q;

  assign abort = filt_any && !cpu_accept && !cpu_reject
              && (cyc_q == CW'(CYC_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (start) begin
      cyc_q <= '0;
    end else if (filt_any) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end
`else
  logic unused_cyc_limit;
  assign unused_cyc_limit = (CYC_LIMIT != 0);
  assign abort = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    len_d    = len_q;
    fill_any = (st_q[0] == FILL) || (st_q[1] == FILL);
    filt_any = (st_q[0] == FILT) || (st_q[1] == FILT);
    grant    = sn_start && !fill_any
            && ((st_q[0] == EMPTY) || (st_q[1] == EMPTY));
    gsel     = (st_q[0] != EMPTY);
    start    = !filt_any
            && ((st_q[0] == READY) || (st_q[1] == READY));
    ssel     = ((st_q[0] == READY) && (st_q[1] == READY))
            ? ready_first : (st_q[1] == READY);
    for (int i = 0; i < 2; i++) begin
      case (st_q[i])
        EMPTY: if (grant && gsel == 1'(i)) st_d[i] = FILL;
        FILL: if (sn_done) begin
          st_d[i]  = (sn_len == '0) ? EMPTY : READY;
          len_d[i] = sn_len;
        end
        READY: if (start && ssel == 1'(i)) st_d[i] = FILT;
        FILT: begin
          if (cpu_reject || abort) st_d[i] = EMPTY;
          else if (cpu_accept)     st_d[i] = FWD;
        end
        FWD: if (fwd_done && fwd_valid && fwd_sel == 1'(i)) st_d[i] = EMPTY;
        default: st_d[i] = EMPTY;
      endcase
    end
    // When both are queued, the one already waiting keeps priority.
    rf_d = ready_first;
    if (st_d[0] == READY && st_d[1] == READY) begin
      rf_d = (st_q[0] == READY && st_q[1] == READY)
           ? ready_first : (st_q[0] != READY);
    end else if (st_d[0] == READY || st_d[1] == READY) begin
      rf_d = (st_d[1] == READY);
    end
    ff_d = fwd_first;
    if (st_d[0] == FWD && st_d[1] == FWD) begin
      ff_d = (st_q[0] == FWD && st_q[1] == FWD)
           ? fwd_first : (st_q[0] != FWD);
    end else if (st_d[0] == FWD || st_d[1] == FWD) begin
      ff_d = (st_d[1] == FWD);
    end
    fill_s_d = (st_d[1] == FILL);
    filt_s_d = (st_d[1] == FILT);
    fwd_v_d  = (st_d[0] == FWD) || (st_d[1] == FWD);
    fwd_s_d  = (st_d[0] == FWD && st_d[1] == FWD) ? ff_d : (st_d[1] == FWD);
    plen_d   = ((st_d[0] == FILT) || (st_d[1] == FILT))
             ? 32'(len_d[filt_s_d]) : 32'd0;
    flen_d   = fwd_v_d ? len_d[fwd_s_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q          <= '{EMPTY, EMPTY};
      len_q         <= '{'0, '0};
      ready_first   <= 1'b0;
      fwd_first     <= 1'b0;
      sn_grant      <= 1'b0;
      sn_sel        <= 1'b0;
      cpu_mem_ready <= 1'b0;
      cpu_sel       <= 1'b0;
      packet_len    <= '0;
      cpu_abort     <= 1'b0;
      fwd_valid     <= 1'b0;
      fwd_sel       <= 1'b0;
      fwd_len       <= '0;
    end else begin
      st_q          <= st_d;
      len_q         <= len_d;
      ready_first   <= rf_d;
      fwd_first     <= ff_d;
      sn_grant      <= grant;
      sn_sel        <= fill_s_d;
      cpu_mem_ready <= start;
      cpu_sel       <= filt_s_d;
      packet_len    <= plen_d;
      cpu_abort     <= abort;
      fwd_valid     <= fwd_v_d;
      fwd_sel       <= fwd_s_d;
      fwd_len       <= flen_d;
    end
  end
endmodule

// File: tb/tb_bpf_pkt_sched.sv
// tb_bpf_pkt_sched: directed + randomized bench for bpf_pkt_sched
// against a queue-based behavioural model.
module tb_bpf_pkt_sched;
  localparam int PW = 11;
`ifdef BPF_CYC_LIMIT_EN
  localparam int CL = 16;
`else
  localparam int CL = 1024;
`endif
  localparam int M_EMPTY = 0;
  localparam int M_FILL  = 1;
  localparam int M_READY = 2;
  localparam int M_FILT  = 3;
  localparam int M_FWD   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sn_start = 1'b0, sn_done = 1'b0;
  logic [PW-1:0] sn_len = '0;
  logic          cpu_accept = 1'b0, cpu_reject = 1'b0, fwd_done = 1'b0;
  logic          sn_grant, sn_sel, cpu_mem_ready, cpu_sel, cpu_abort;
  logic          fwd_valid, fwd_sel;
  logic [31:0]   packet_len;
  logic [PW-1:0] fwd_len;

  bpf_pkt_sched #(.PLEN_WIDTH(PW), .CYC_LIMIT(CL)) dut (
    .clk(clk), .rst(rst),
    .sn_start(sn_start), .sn_grant(sn_grant), .sn_sel(sn_sel),
    .sn_done(sn_done), .sn_len(sn_len),
    .cpu_mem_ready(cpu_mem_ready), .cpu_sel(cpu_sel),
    .packet_len(packet_len),
    .cpu_accept(cpu_accept), .cpu_reject(cpu_reject),
    .cpu_abort(cpu_abort),
    .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_len(fwd_len),
    .fwd_done(fwd_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: buffer states plus arrival-order queues.
  int m_st [2];
  int m_len [2];
  int rq [$];
  int fq [$];
  bit e_grant, e_mr, e_abort;
  int filt_cycles;

  function automatic int find(input int s);
    for (int i = 0; i < 2; i++) if (m_st[i] == s) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int f, c, g, d;
    bit ab;
    if (!rst) begin
      m_st = '{M_EMPTY, M_EMPTY};
      m_len = '{0, 0};
      rq.delete();
      fq.delete();
      e_grant = 0; e_mr = 0; e_abort = 0;
      filt_cycles = 0;
    end else begin
      e_grant = 0; e_mr = 0; e_abort = 0;
      f = find(M_FILL);
      c = find(M_FILT);
      g = (sn_start && f < 0) ? find(M_EMPTY) : -1;
      if (fwd_done && fq.size() > 0) begin
        d = fq.pop_front();
        m_st[d] = M_EMPTY;
      end
      if (c >= 0) begin
        ab = 0;
`ifdef BPF_CYC_LIMIT_EN
        if (!cpu_accept && !cpu_reject) begin
          filt_cycles++;
          ab = (filt_cycles == CL);
        end
`endif
        e_abort = ab;
        if (cpu_reject || ab) m_st[c] = M_EMPTY;
        else if (cpu_accept) begin
          m_st[c] = M_FWD;
          fq.push_back(c);
        end
      end
      if (c < 0 && rq.size() > 0) begin
        d = rq.pop_front();
        m_st[d] = M_FILT;
        e_mr = 1;
        filt_cycles = 0;
      end
      if (f >= 0 && sn_done) begin
        if (sn_len == 0) m_st[f] = M_EMPTY;
        else begin
          m_st[f] = M_READY;
          m_len[f] = int'(sn_len);
          rq.push_back(f);
        end
      end
      if (g >= 0) begin
        m_st[g] = M_FILL;
        e_grant = 1;
      end
    end
  end

  always @(negedge clk) begin
    int fi, ti, pl;
    if (chk_en) begin
      fi = find(M_FILL);
      ti = find(M_FILT);
      pl = (ti >= 0) ? m_len[ti] : 0;
      chk("m_sn_grant", 32'(sn_grant), 32'(e_grant));
      chk("m_mem_ready", 32'(cpu_mem_ready), 32'(e_mr));
      chk("m_packet_len", packet_len, 32'(pl));
      chk("m_cpu_abort", 32'(cpu_abort), 32'(e_abort));
      chk("m_fwd_valid", 32'(fwd_valid), 32'(fq.size() > 0));
      if (fi >= 0) chk("m_sn_sel", 32'(sn_sel), 32'(fi));
      if (ti >= 0) chk("m_cpu_sel", 32'(cpu_sel), 32'(ti));
      if (fq.size() > 0) begin
        chk("m_fwd_sel", 32'(fwd_sel), 32'(fq[0]));
        chk("m_fwd_len", 32'(fwd_len), 32'(m_len[fq[0]]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_grant"}, 32'(sn_grant), 0);
    chk({nm, "_sn_sel"}, 32'(sn_sel), 0);
    chk({nm, "_mr"}, 32'(cpu_mem_ready), 0);
    chk({nm, "_cpu_sel"}, 32'(cpu_sel), 0);
    chk({nm, "_plen"}, packet_len, 0);
    chk({nm, "_abort"}, 32'(cpu_abort), 0);
    chk({nm, "_fv"}, 32'(fwd_valid), 0);
    chk({nm, "_fsel"}, 32'(fwd_sel), 0);
    chk({nm, "_flen"}, 32'(fwd_len), 0);
  endtask

  initial begin
    int aborts;
    repeat (3) tick();
    chk_en = 1'b1;
    chk_all_zero("reset");
    rst = 1'b1;

    // single packet through to the CPU
    sn_start = 1; tick();
    chk("d1_grant", 32'(sn_grant), 1);
    chk("d1_sn_sel", 32'(sn_sel), 0);
    sn_start = 0; sn_done = 1; sn_len = 64; tick();
    sn_done = 0;
    chk("d1_no_mr", 32'(cpu_mem_ready), 0);
    tick();
    chk("d1_mr", 32'(cpu_mem_ready), 1);
    chk("d1_cpu_sel", 32'(cpu_sel), 0);
    chk("d1_plen", packet_len, 64);
    tick();
    chk("d1_mr_drop", 32'(cpu_mem_ready), 0);
    cpu_reject = 1; tick(); cpu_reject = 0;
    chk("d1_plen0", packet_len, 0);

    // CPU busy, reject frees buffer 0, regrant one cycle later
    sn_start = 1; tick();
    sn_start = 0; sn_done = 1; sn_len = 60; tick();
    sn_done = 0; sn_start = 1; tick();
    chk("d2_plen60", packet_len, 60);
    chk("d2_grant1", 32'(sn_grant), 1);
    chk("d2_sel1", 32'(sn_sel), 1);
    sn_done = 1; sn_len = 100; tick();
    sn_done = 0; tick();
    chk("d2_busy", packet_len, 60);
    chk("d2_nogrant", 32'(sn_grant), 0);
    cpu_reject = 1; tick(); cpu_reject = 0;
    chk("d2_freed_plen", packet_len, 0);
    chk("d2_no_regrant", 32'(sn_grant), 0);
    tick();
    chk("d2_plen100", packet_len, 100);
    chk("d2_cpu_sel1", 32'(cpu_sel), 1);
    chk("d2_mr", 32'(cpu_mem_ready), 1);
    chk("d2_regrant", 32'(sn_grant), 1);
    chk("d2_regrant_sel", 32'(sn_sel), 0);
    sn_start = 0;

    // forwarding order follows acceptance order
    sn_done = 1; sn_len = 60; cpu_accept = 1; tick();
    sn_done = 0; cpu_accept = 0;
    chk("d3_fv", 32'(fwd_valid), 1);
    chk("d3_fsel1", 32'(fwd_sel), 1);
    chk("d3_flen100", 32'(fwd_len), 100);
    tick();
    chk("d3_plen60", packet_len, 60);
    cpu_accept = 1; tick(); cpu_accept = 0;
    chk("d3_both_fsel", 32'(fwd_sel), 1);
    chk("d3_both_flen", 32'(fwd_len), 100);
    sn_start = 1; tick();
    chk("d3_full_nogrant", 32'(sn_grant), 0);
    fwd_done = 1; tick(); fwd_done = 0;
    chk("d3_fsel0", 32'(fwd_sel), 0);
    chk("d3_flen60", 32'(fwd_len), 60);
    chk("d3_nogrant_freed", 32'(sn_grant), 0);
    tick();
    chk("d3_grant", 32'(sn_grant), 1);
    chk("d3_grant_sel", 32'(sn_sel), 1);
    sn_start = 0;

    // runt drop concurrent with drain of the other buffer
    sn_done = 1; sn_len = 0; fwd_done = 1; tick();
    sn_done = 0; fwd_done = 0;
    chk("d4_fv0", 32'(fwd_valid), 0);
    tick();
    chk("d4_runt_mr", 32'(cpu_mem_ready), 0);
    chk("d4_runt_plen", packet_len, 0);

    // accept together with reject acts as reject
    sn_start = 1; tick();
    sn_start = 0; sn_done = 1; sn_len = 33; tick();
    sn_done = 0; tick();
    chk("d5_plen33", packet_len, 33);
    cpu_accept = 1; cpu_reject = 1; tick();
    cpu_accept = 0; cpu_reject = 0;
    chk("d5_fv0", 32'(fwd_valid), 0);
    chk("d5_plen0", packet_len, 0);
    tick();
    chk("d5_fv0b", 32'(fwd_valid), 0);

    // reset while forwarding
    sn_start = 1; tick();
    sn_start = 0; sn_done = 1; sn_len = 77; tick();
    sn_done = 0; tick();
    cpu_accept = 1; tick(); cpu_accept = 0;
    chk("d6_fv", 32'(fwd_valid), 1);
    chk("d6_flen77", 32'(fwd_len), 77);
    sn_start = 1; tick();
    chk("d6_grant", 32'(sn_grant), 1);
    rst = 0; tick();
    chk_all_zero("midrst");
    rst = 1; sn_start = 0;

    // CPU never answers
    sn_start = 1; tick();
    sn_start = 0; sn_done = 1; sn_len = 200; tick();
    sn_done = 0; tick();
    chk("d7_plen200", packet_len, 200);
    aborts = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cpu_abort === 1'b1) aborts++;
    end
`ifdef BPF_CYC_LIMIT_EN
    chk("d7_aborts", 32'(aborts), 1);
    chk("d7_plen_end", packet_len, 0);
`else
    chk("d7_aborts", 32'(aborts), 0);
    chk("d7_plen_end", packet_len, 200);
`endif
    cpu_reject = 1; tick(); cpu_reject = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) != 0);
      sn_start   = ($urandom_range(0, 1) == 0);
      sn_done    = ($urandom_range(0, 9) < 3);
      sn_len     = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 2047));
      cpu_accept = ($urandom_range(0, 9) < 2);
      cpu_reject = ($urandom_range(0, 9) == 0);
      fwd_done   = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1; sn_start = 0; sn_done = 0;
    cpu_accept = 0; cpu_reject = 0; fwd_done = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
